// File: rtl/playfield_bg_ctrl_if.sv
// Pixel, piece and status signals between the playfield engine and its neighbours.
interface playfield_bg_ctrl_if;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [9:0]  xadd;
    logic [9:0]  yadd;
    logic [1:0]  x0;
    logic [1:0]  y0;
    logic [1:0]  x1;
    logic [1:0]  y1;
    logic [1:0]  x2;
    logic [1:0]  y2;
    logic [1:0]  x3;
    logic [1:0]  y3;
    logic [2:0]  shape;
    logic [1:0]  direction;
    logic [31:0] new_score;
    logic [23:0] bgr_data_raw;
    logic        move_reset;
    logic        nl;
    logic        nr;
    logic [31:0] current_score;
    logic        lflag;

    modport master (
        output x, y, xadd, yadd, x0, y0, x1, y1, x2, y2, x3, y3,
               shape, direction, new_score,
        input  bgr_data_raw, move_reset, nl, nr, current_score, lflag
    );

    modport slave (
        input  x, y, xadd, yadd, x0, y0, x1, y1, x2, y2, x3, y3,
               shape, direction, new_score,
        output bgr_data_raw, move_reset, nl, nr, current_score, lflag
    );
endinterface

// File: rtl/playfield_bg_ctrl.sv
// Tetris playfield: locked-cell grid, background render, blocking, lock, row clear, score.
module playfield_bg_ctrl #(
    parameter int unsigned LOCK_DELAY = 11_000_000
) (
    input  logic               VGA_CLK_n,
    input  logic               iRST_n,
    playfield_bg_ctrl_if.slave pf
);

    localparam int unsigned COLS  = 10;
    localparam int unsigned ROWS  = 20;
    localparam int unsigned CELL  = 20;
    localparam int unsigned X_ORG = 220;
    localparam int unsigned Y_ORG = 40;
    localparam int unsigned CNT_W = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [COLS-1:0]  occ_q [ROWS];
    logic [2:0]       shp_q [ROWS][COLS];
    logic [0:0]       state_q, state_d;
    logic [4:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_c, shift_c, go_c, row_full_c;
    logic             nl_c, nr_c, down_c;
    logic [10:0]      pc_col [4];
    logic [10:0]      pc_row [4];
    logic [3:0]       pc_c4  [4];
    logic [4:0]       pc_r5  [4];
    logic             pc_ok  [4];
    logic [9:0]       dx, dy;
    logic [3:0]       cc;
    logic [4:0]       rr;
    logic             in_pf, on_line;
    logic [23:0]      bgr_c, bgr_q;
    logic             down_q, move_reset_q, nl_q, nr_q, lflag_q;
    logic [31:0]      score_q, new_score_q;
    logic [1:0]       unused_direction;

    assign unused_direction = pf.direction;

    function automatic logic [23:0] palette(input logic [2:0] s);
        case (s)
            3'd0:    palette = 24'hFF0000;
            3'd1:    palette = 24'h00FF00;
            3'd2:    palette = 24'h0000FF;
            3'd3:    palette = 24'h00FFFF;
            3'd4:    palette = 24'hFF00FF;
            3'd5:    palette = 24'hFFFF00;
            3'd6:    palette = 24'h808080;
            default: palette = 24'hFFFFFF;
        endcase
    endfunction

    // Absolute piece cells, widened so out-of-range positions are detectable
    always_comb begin
        pc_col[0] = 11'(pf.xadd) + 11'(pf.x0);
        pc_row[0] = 11'(pf.yadd) + 11'(pf.y0);
        pc_col[1] = 11'(pf.xadd) + 11'(pf.x1);
        pc_row[1] = 11'(pf.yadd) + 11'(pf.y1);
        pc_col[2] = 11'(pf.xadd) + 11'(pf.x2);
        pc_row[2] = 11'(pf.yadd) + 11'(pf.y2);
        pc_col[3] = 11'(pf.xadd) + 11'(pf.x3);
        pc_row[3] = 11'(pf.yadd) + 11'(pf.y3);
        for (int i = 0; i < 4; i++) begin
            pc_ok[i] = (pc_col[i] < 11'(COLS)) && (pc_row[i] < 11'(ROWS));
            pc_c4[i] = 4'(pc_col[i]);
            pc_r5[i] = 5'(pc_row[i]);
        end
    end

    // Neighbour blocking; an out-of-range cell blocks every direction
    always_comb begin
        nl_c   = 1'b0;
        nr_c   = 1'b0;
        down_c = 1'b0;
        go_c   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!pc_ok[i]) begin
                nl_c   = 1'b1;
                nr_c   = 1'b1;
                down_c = 1'b1;
            end else begin
                if (pc_c4[i] == 4'd0 || occ_q[pc_r5[i]][pc_c4[i] - 4'd1])
                    nl_c = 1'b1;
                if (pc_c4[i] == 4'd9 || occ_q[pc_r5[i]][pc_c4[i] + 4'd1])
                    nr_c = 1'b1;
                if (pc_r5[i] == 5'd19 || occ_q[pc_r5[i] + 5'd1][pc_c4[i]])
                    down_c = 1'b1;
                if (pc_r5[i] == 5'd0)
                    go_c = 1'b1;
            end
        end
    end

    assign row_full_c = &occ_q[ptr_q];

    always_ff @(posedge VGA_CLK_n or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 5'd19;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Lock counter and row-clear scan
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        lock_c  = 1'b0;
        shift_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (lflag_q || !down_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(LOCK_DELAY - 1)) begin
                    lock_c  = 1'b1;
                    cnt_d   = '0;
                    ptr_d   = 5'd19;
                    state_d = S_CLEAR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CLEAR: begin
                cnt_d = '0;
                if (row_full_c)
                    shift_c = 1'b1;
                else if (ptr_q == 5'd0)
                    state_d = S_IDLE;
                else
                    ptr_d = ptr_q - 5'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Grid storage: piece write on lock, collapse above a full row during clear
    always_ff @(posedge VGA_CLK_n or negedge iRST_n) begin
        if (!iRST_n) begin
            for (int r = 0; r < ROWS; r++) begin
                occ_q[r] <= '0;
                for (int c = 0; c < COLS; c++) shp_q[r][c] <= '0;
            end
        end else if (lock_c) begin
            for (int i = 0; i < 4; i++) begin
                if (pc_ok[i]) begin
                    occ_q[pc_r5[i]][pc_c4[i]] <= 1'b1;
                    shp_q[pc_r5[i]][pc_c4[i]] <= pf.shape;
                end
            end
        end else if (shift_c) begin
            for (int r = ROWS - 1; r > 0; r--) begin
                if (5'(r) <= ptr_q) begin
                    occ_q[r] <= occ_q[r-1];
                    for (int c = 0; c < COLS; c++) shp_q[r][c] <= shp_q[r-1][c];
                end
            end
            occ_q[0] <= '0;
            for (int c = 0; c < COLS; c++) shp_q[0][c] <= '0;
        end
    end

    // Background colour of the current pixel
    always_comb begin
        dx      = pf.x - 10'(X_ORG);
        dy      = pf.y - 10'(Y_ORG);
        in_pf   = (pf.x >= 10'(X_ORG)) && (pf.x < 10'(X_ORG + COLS * CELL)) &&
                  (pf.y >= 10'(Y_ORG)) && (pf.y < 10'(Y_ORG + ROWS * CELL));
        cc      = 4'(dx / 10'(CELL));
        rr      = 5'(dy / 10'(CELL));
        on_line = (dx % 10'(CELL) == 10'(CELL - 1)) || (dy % 10'(CELL) == 10'(CELL - 1));
        bgr_c   = 24'h000000;
        if (in_pf) begin
            if (occ_q[rr][cc])
                bgr_c = palette(shp_q[rr][cc]);
            else if (on_line)
                bgr_c = 24'h202020;
            else
                bgr_c = 24'h404040;
        end
    end

    always_ff @(posedge VGA_CLK_n or negedge iRST_n) begin
        if (!iRST_n) begin
            bgr_q        <= '0;
            nl_q         <= 1'b0;
            nr_q         <= 1'b0;
            down_q       <= 1'b0;
            move_reset_q <= 1'b0;
            lflag_q      <= 1'b0;
            new_score_q  <= '0;
            score_q      <= '0;
        end else begin
            bgr_q        <= bgr_c;
            nl_q         <= nl_c;
            nr_q         <= nr_c;
            down_q       <= down_c;
            move_reset_q <= lock_c;
            if (lock_c && go_c)
                lflag_q <= 1'b1;
            new_score_q <= pf.new_score;
            // an external load takes priority over a row-clear increment
            if (pf.new_score != new_score_q)
                score_q <= pf.new_score;
            else if (shift_c)
                score_q <= score_q + 32'd1;
        end
    end

    assign pf.bgr_data_raw  = bgr_q;
    assign pf.nl            = nl_q;
    assign pf.nr            = nr_q;
    assign pf.move_reset    = move_reset_q;
    assign pf.lflag         = lflag_q;
    assign pf.current_score = score_q;

endmodule

// File: tb/tb_playfield_bg_ctrl.sv
// Randomised bench for playfield_bg_ctrl against a grid-level reference model.
module tb_playfield_bg_ctrl;

    localparam int unsigned LD = 4;

    logic VGA_CLK_n = 1'b0;
    logic iRST_n    = 1'b0;

    playfield_bg_ctrl_if pf();

    playfield_bg_ctrl #(.LOCK_DELAY(LD)) dut (
        .VGA_CLK_n (VGA_CLK_n),
        .iRST_n    (iRST_n),
        .pf        (pf)
    );

    always #5 VGA_CLK_n = ~VGA_CLK_n;

    int checks = 0;
    int errors = 0;

    int grid [20][10];
    int m_score;
    bit m_lflag;
    logic [23:0] pal [8] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h00FFFF,
                             24'hFF00FF, 24'hFFFF00, 24'h808080, 24'hFFFFFF};

    int p_xadd, p_yadd, p_shape;
    int p_xo [4];
    int p_yo [4];

    task automatic tick();
        @(posedge VGA_CLK_n);
        #1;
    endtask

    task automatic drive_piece();
        pf.xadd  = 10'(p_xadd);
        pf.yadd  = 10'(p_yadd);
        pf.x0 = 2'(p_xo[0]); pf.y0 = 2'(p_yo[0]);
        pf.x1 = 2'(p_xo[1]); pf.y1 = 2'(p_yo[1]);
        pf.x2 = 2'(p_xo[2]); pf.y2 = 2'(p_yo[2]);
        pf.x3 = 2'(p_xo[3]); pf.y3 = 2'(p_yo[3]);
        pf.shape = 3'(p_shape);
        pf.direction = 2'($urandom_range(0, 3));
    endtask

    task automatic set_piece(input int c, input int r, input int s,
                             input int xo0, input int xo1, input int xo2, input int xo3,
                             input int yo0, input int yo1, input int yo2, input int yo3);
        p_xadd = c; p_yadd = r; p_shape = s;
        p_xo[0] = xo0; p_xo[1] = xo1; p_xo[2] = xo2; p_xo[3] = xo3;
        p_yo[0] = yo0; p_yo[1] = yo1; p_yo[2] = yo2; p_yo[3] = yo3;
        drive_piece();
    endtask

    task automatic set_cell(input int c, input int r);
        set_piece(c, r, $urandom_range(0, 7), 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic set_hbar(input int c, input int r);
        set_piece(c, r, $urandom_range(0, 7), 0, 1, 2, 3, 0, 0, 0, 0);
    endtask

    task automatic set_vbar(input int c, input int r);
        set_piece(c, r, $urandom_range(0, 7), 0, 0, 0, 0, 0, 1, 2, 3);
    endtask

    // Free-floating spot where nothing in these scenarios blocks a fall
    task automatic park();
        set_cell(4, 2);
    endtask

    function automatic bit m_occ(input int c, input int r);
        if (c < 0 || c > 9 || r < 0 || r > 19) return 1'b0;
        return grid[r][c] >= 0;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++) grid[r][c] = -1;
        m_score = 0;
        m_lflag = 1'b0;
    endfunction

    // Drop every full row and let the rest fall; score counts dropped rows
    function automatic void model_collapse();
        int nxt [20][10];
        int dst;
        int cleared;
        dst = 19;
        cleared = 0;
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++) nxt[r][c] = -1;
        for (int r = 19; r >= 0; r--) begin
            bit full;
            full = 1'b1;
            for (int c = 0; c < 10; c++) if (grid[r][c] < 0) full = 1'b0;
            if (full) cleared++;
            else begin
                for (int c = 0; c < 10; c++) nxt[dst][c] = grid[r][c];
                dst--;
            end
        end
        grid = nxt;
        m_score += cleared;
    endfunction

    function automatic void model_lock();
        for (int i = 0; i < 4; i++) begin
            int c, r;
            c = p_xadd + p_xo[i];
            r = p_yadd + p_yo[i];
            if (c <= 9 && r <= 19) begin
                grid[r][c] = p_shape;
                if (r == 0) m_lflag = 1'b1;
            end
        end
        model_collapse();
    endfunction

    function automatic logic [23:0] exp_color(input int px, input int py);
        int c, r;
        if (px < 220 || px >= 420 || py < 40 || py >= 440) return 24'h000000;
        c = (px - 220) / 20;
        r = (py - 40) / 20;
        if (grid[r][c] >= 0) return pal[grid[r][c]];
        if ((px - 220) % 20 == 19 || (py - 40) % 20 == 19) return 24'h202020;
        return 24'h404040;
    endfunction

    function automatic bit exp_nl();
        bit b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int c, r;
            c = p_xadd + p_xo[i];
            r = p_yadd + p_yo[i];
            if (c > 9 || r > 19 || c == 0 || m_occ(c - 1, r)) b = 1'b1;
        end
        return b;
    endfunction

    function automatic bit exp_nr();
        bit b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int c, r;
            c = p_xadd + p_xo[i];
            r = p_yadd + p_yo[i];
            if (c > 9 || r > 19 || c == 9 || m_occ(c + 1, r)) b = 1'b1;
        end
        return b;
    endfunction

    task automatic do_reset();
        iRST_n = 1'b0;
        park();
        pf.x = '0;
        pf.y = '0;
        pf.new_score = '0;
        model_reset();
        repeat (2) tick();
        iRST_n = 1'b1;
        tick();
    endtask

    // Wait (bounded) for the lock pulse of the driven piece, then let the clear finish
    task automatic do_lock();
        bit seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (pf.move_reset === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL lock_timeout move_reset=0 required 1 within 20 clocks");
        end else begin
            model_lock();
        end
        park();
        repeat (30) tick();
    endtask

    task automatic test_render_scan();
        for (int r = 0; r < 20; r++) begin
            for (int c = 0; c < 10; c++) begin
                int px, py;
                px = 220 + 20 * c + $urandom_range(0, 19);
                py = 40 + 20 * r + $urandom_range(0, 19);
                pf.x = 10'(px);
                pf.y = 10'(py);
                tick();
                checks++;
                if (pf.bgr_data_raw !== exp_color(px, py)) begin
                    errors++;
                    $display("FAIL render(%0d,%0d) got %h required %h",
                             px, py, pf.bgr_data_raw, exp_color(px, py));
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            int px, py;
            px = $urandom_range(0, 639);
            py = $urandom_range(0, 479);
            pf.x = 10'(px);
            pf.y = 10'(py);
            tick();
            checks++;
            if (pf.bgr_data_raw !== exp_color(px, py)) begin
                errors++;
                $display("FAIL render_any(%0d,%0d) got %h required %h",
                         px, py, pf.bgr_data_raw, exp_color(px, py));
            end
        end
    endtask

    task automatic test_reset();
        int px [3] = '{0, 220, 239};
        int py [3] = '{0, 40, 59};
        iRST_n = 1'b0;
        park();
        pf.x = 10'd300;
        pf.y = 10'd300;
        pf.new_score = '0;
        model_reset();
        repeat (2) tick();
        checks++;
        if (pf.bgr_data_raw !== 24'h0 || pf.move_reset !== 1'b0) begin
            errors++;
            $display("FAIL reset_bgr_mr got %h/%b required 000000/0", pf.bgr_data_raw, pf.move_reset);
        end
        checks++;
        if (pf.nl !== 1'b0 || pf.nr !== 1'b0) begin
            errors++;
            $display("FAIL reset_nl_nr got %b%b required 00", pf.nl, pf.nr);
        end
        checks++;
        if (pf.current_score !== 32'd0 || pf.lflag !== 1'b0) begin
            errors++;
            $display("FAIL reset_score_lflag got %0d/%b required 0/0", pf.current_score, pf.lflag);
        end
        iRST_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            pf.x = 10'(px[k]);
            pf.y = 10'(py[k]);
            tick();
            checks++;
            if (pf.bgr_data_raw !== exp_color(px[k], py[k])) begin
                errors++;
                $display("FAIL reset_pixel(%0d,%0d) got %h required %h",
                         px[k], py[k], pf.bgr_data_raw, exp_color(px[k], py[k]));
            end
        end
    endtask

    task automatic test_lock_delay();
        int n = 0;
        bit seen = 1'b0;
        do_reset();
        set_piece(4, 18, 3, 0, 1, 0, 1, 0, 0, 1, 1);
        while (!seen && n < 20) begin
            tick();
            n++;
            if (pf.move_reset === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || n != LD + 1) begin
            errors++;
            $display("FAIL lock_latency got %0d clocks (seen=%b) required %0d", n, seen, LD + 1);
        end
        if (seen) model_lock();
        park();
        tick();
        checks++;
        if (pf.move_reset !== 1'b0) begin
            errors++;
            $display("FAIL lock_pulse_width move_reset=%b required 0", pf.move_reset);
        end
        repeat (30) tick();
        pf.x = 10'd310;
        pf.y = 10'd430;
        tick();
        checks++;
        if (pf.bgr_data_raw !== exp_color(310, 430)) begin
            errors++;
            $display("FAIL lock_pixel got %h required %h", pf.bgr_data_raw, exp_color(310, 430));
        end
        test_render_scan();
    endtask

    task automatic test_blocking();
        do_reset();
        set_cell(0, 5);
        tick();
        checks++;
        if (pf.nl !== exp_nl() || pf.nr !== exp_nr()) begin
            errors++;
            $display("FAIL block_col0 got nl=%b nr=%b required nl=%b nr=%b", pf.nl, pf.nr, exp_nl(), exp_nr());
        end
        park();
        tick();
        set_cell(6, 19);
        do_lock();
        set_cell(5, 19);
        tick();
        checks++;
        if (pf.nl !== exp_nl() || pf.nr !== exp_nr()) begin
            errors++;
            $display("FAIL block_right_nbr got nl=%b nr=%b required nl=%b nr=%b", pf.nl, pf.nr, exp_nl(), exp_nr());
        end
        park();
        repeat (2) tick();
        set_vbar(2, 16);
        do_lock();
        set_cell(8, 19);
        do_lock();
        for (int k = 0; k < 24; k++) begin
            set_piece($urandom_range(0, 10), $urandom_range(0, 20), $urandom_range(0, 7),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            tick();
            checks++;
            if (pf.nl !== exp_nl() || pf.nr !== exp_nr()) begin
                errors++;
                $display("FAIL block_rand xadd=%0d yadd=%0d got nl=%b nr=%b required nl=%b nr=%b",
                         p_xadd, p_yadd, pf.nl, pf.nr, exp_nl(), exp_nr());
            end
            park();
            tick();
        end
    endtask

    task automatic test_row_clear();
        do_reset();
        set_hbar(0, 19); do_lock();
        set_hbar(4, 19); do_lock();
        set_cell(8, 19); do_lock();
        set_cell(1, 18); do_lock();
        set_cell(7, 18); do_lock();
        set_cell(9, 19); do_lock();
        checks++;
        if (pf.current_score !== 32'(m_score)) begin
            errors++;
            $display("FAIL single_clear_score got %0d required %0d", pf.current_score, m_score);
        end
        test_render_scan();
    endtask

    task automatic test_double_clear();
        do_reset();
        set_hbar(0, 19); do_lock();
        set_hbar(4, 19); do_lock();
        set_cell(8, 19); do_lock();
        set_hbar(0, 18); do_lock();
        set_hbar(4, 18); do_lock();
        set_cell(8, 18); do_lock();
        set_cell(2, 17); do_lock();
        set_cell(5, 17); do_lock();
        set_piece(9, 18, $urandom_range(0, 7), 0, 0, 0, 0, 0, 1, 0, 1);
        do_lock();
        checks++;
        if (pf.current_score !== 32'(m_score)) begin
            errors++;
            $display("FAIL double_clear_score got %0d required %0d", pf.current_score, m_score);
        end
        test_render_scan();
    endtask

    task automatic test_game_over();
        bit pulsed = 1'b0;
        logic [31:0] v;
        do_reset();
        for (int r = 16; r >= 0; r -= 4) begin
            set_vbar(3, r);
            do_lock();
        end
        checks++;
        if (pf.lflag !== m_lflag) begin
            errors++;
            $display("FAIL game_over_flag got %b required %b", pf.lflag, m_lflag);
        end
        set_cell(0, 19);
        for (int n = 0; n < 20; n++) begin
            tick();
            if (pf.move_reset === 1'b1) pulsed = 1'b1;
        end
        checks++;
        if (pulsed) begin
            errors++;
            $display("FAIL game_over_no_lock move_reset pulsed=1 required 0");
        end
        park();
        pf.new_score = 32'd50;
        tick();
        checks++;
        if (pf.current_score !== 32'd50) begin
            errors++;
            $display("FAIL score_load got %0d required 50", pf.current_score);
        end
        v = $urandom;
        pf.new_score = v;
        tick();
        checks++;
        if (pf.current_score !== v) begin
            errors++;
            $display("FAIL score_load_rand got %0d required %0d", pf.current_score, v);
        end
        repeat (5) tick();
        checks++;
        if (pf.lflag !== 1'b1 || pf.current_score !== v) begin
            errors++;
            $display("FAIL sticky_state got lflag=%b score=%0d required 1/%0d", pf.lflag, pf.current_score, v);
        end
    endtask

    task automatic test_reset_mid_clear();
        bit seen = 1'b0;
        do_reset();
        pf.new_score = 32'd7;
        tick();
        checks++;
        if (pf.current_score !== 32'd7) begin
            errors++;
            $display("FAIL preload_score got %0d required 7", pf.current_score);
        end
        set_hbar(0, 19);
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (pf.move_reset === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_clear_lock_timeout move_reset=0 required 1");
        end
        park();
        repeat (3) tick();
        #2;
        iRST_n = 1'b0;
        #1;
        checks++;
        if (pf.current_score !== 32'd0 || pf.move_reset !== 1'b0 || pf.bgr_data_raw !== 24'h0) begin
            errors++;
            $display("FAIL async_reset got score=%0d mr=%b bgr=%h required 0/0/000000",
                     pf.current_score, pf.move_reset, pf.bgr_data_raw);
        end
        model_reset();
        pf.new_score = '0;
        tick();
        iRST_n = 1'b1;
        tick();
        pf.x = 10'd230;
        pf.y = 10'd430;
        tick();
        checks++;
        if (pf.bgr_data_raw !== exp_color(230, 430)) begin
            errors++;
            $display("FAIL mid_clear_grid got %h required %h", pf.bgr_data_raw, exp_color(230, 430));
        end
    endtask

    initial begin
        test_reset();
        test_lock_delay();
        test_blocking();
        test_row_clear();
        test_double_clear();
        test_game_over();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
